tlb_array: RTL and testbench

//  TLB storage; receiving end of the MMU's tlb_w_req_t / tlb_inv_req_t streams.

---
 rtl/tlb_array_pkg.sv | 66 ++++++
 rtl/tlb_entry_match.sv | 44 ++++
 rtl/tlb_array.sv | 176 +++++++++++++++++
 tb/tb_tlb_array.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_array_pkg.sv
// Purpose: shared types and constants for the TLB storage array.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: array geometry, page-size codes, INVTLB op codes, entry/request structs, FSM state type.
package tlb_array_pkg;

  // Array geometry. Request structs depend on it, so it lives here as the single source.
  localparam int TLB_ENTRY_NUM = 32;   // power of two
  localparam int SWEEP_WIDTH   = 4;    // must divide TLB_ENTRY_NUM
  localparam int INDEX_LEN     = $clog2(TLB_ENTRY_NUM);

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  // INVTLB op codes
  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;
  localparam logic [4:0] INV_LAST_OP    = INV_GA_VA;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
  } tlb_key_t;

  typedef struct packed {
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_value_t;

  typedef struct packed {
    tlb_key_t   key;
    tlb_value_t value;
  } tlb_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [INDEX_LEN-1:0] index;
    tlb_entry_t           entry;
  } tlb_w_req_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [18:0] vppn;
  } tlb_inv_req_t;

  typedef enum logic {ST_IDLE, ST_SWEEP} tlb_state_e;

endpackage

// File: rtl/tlb_entry_match.sv
// Purpose: per-entry compare of one TLB key against an ASID/VPPN and an INVTLB op.
// Latency: combinational.
// Backpressure: none.
// Ports: key_i, asid_i, vppn_i, op_i in; srch_hit_o (TLBSRCH hit), inv_hit_o (INVTLB predicate true on a valid entry) out.
module tlb_entry_match
  import tlb_array_pkg::*;
(
  input  tlb_key_t    key_i,
  input  logic [9:0]  asid_i,
  input  logic [18:0] vppn_i,
  input  logic [4:0]  op_i,
  output logic        srch_hit_o,
  output logic        inv_hit_o
);

  logic vppn_eq;
  logic asid_eq;
  logic inv_pred;

  always_comb begin
    // 4K pages compare the full VPPN; anything else is treated as a 2M page,
    // whose low 9 VPPN bits fall inside the page offset.
    if (key_i.ps == PS_4K) begin
      vppn_eq = (key_i.vppn == vppn_i);
    end else begin
      vppn_eq = (key_i.vppn[18:9] == vppn_i[18:9]);
    end
    asid_eq = (key_i.asid == asid_i);

    case (op_i)
      INV_ALL0, INV_ALL1: inv_pred = 1'b1;
      INV_G:              inv_pred = key_i.g;
      INV_NG:             inv_pred = !key_i.g;
      INV_NG_ASID:        inv_pred = !key_i.g && asid_eq;
      INV_NG_ASID_VA:     inv_pred = !key_i.g && asid_eq && vppn_eq;
      INV_GA_VA:          inv_pred = (key_i.g || asid_eq) && vppn_eq;
      default:            inv_pred = 1'b0;
    endcase
  end

  assign srch_hit_o = key_i.e && vppn_eq && (key_i.g || asid_eq);
  assign inv_hit_o  = key_i.e && inv_pred;

endmodule

// File: rtl/tlb_array.sv
// Purpose: TLB entry storage; 1-cycle writes, TLBRD/TLBSRCH lookups, INVTLB as a multi-cycle sweep.
// Latency: write commits at the request edge; rd/srch results registered, 1 cycle; INVTLB busy TLB_ENTRY_NUM/SWEEP_WIDTH cycles.
// Backpressure: busy_o high during a sweep; write/inv requests seen then are dropped.
// Ports: clk, rst (sync, active high); tlb_w_req_i, tlb_inv_req_i in; busy_o out;
//        rd_index_i in / rd_entry_o out; srch_valid_i, srch_asid_i, srch_vppn_i in / srch_hit_o, srch_index_o out.
module tlb_array
  import tlb_array_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  tlb_w_req_t           tlb_w_req_i,
  input  tlb_inv_req_t         tlb_inv_req_i,
  output logic                 busy_o,
  input  logic [INDEX_LEN-1:0] rd_index_i,
  output tlb_entry_t           rd_entry_o,
  input  logic                 srch_valid_i,
  input  logic [9:0]           srch_asid_i,
  input  logic [18:0]          srch_vppn_i,
  output logic                 srch_hit_o,
  output logic [INDEX_LEN-1:0] srch_index_o
);

  localparam logic [INDEX_LEN-1:0] PTR_STEP = INDEX_LEN'(SWEEP_WIDTH);
  localparam logic [INDEX_LEN-1:0] PTR_LAST = INDEX_LEN'(TLB_ENTRY_NUM - SWEEP_WIDTH);

  tlb_state_e           state_q, state_d;
  logic [INDEX_LEN-1:0] ptr_q, ptr_d;
  logic [4:0]           op_q, op_d;
  logic [9:0]           asid_q, asid_d;
  logic [18:0]          vppn_q, vppn_d;

  // E bits live in their own vector so reset clears every entry in one cycle;
  // the rest of each entry is payload that never needs a reset.
  logic [TLB_ENTRY_NUM-1:0] e_q, e_d;
  tlb_entry_t               ent_q    [TLB_ENTRY_NUM];
  tlb_entry_t               ent_d    [TLB_ENTRY_NUM];
  tlb_entry_t               ent_view [TLB_ENTRY_NUM];

  tlb_entry_t           rd_entry_q, rd_entry_d;
  logic                 srch_hit_q, srch_hit_d;
  logic [INDEX_LEN-1:0] srch_index_q, srch_index_d;

  logic idle;
  logic wr_fire;
  logic inv_fire;

  assign idle     = (state_q == ST_IDLE);
  assign wr_fire  = idle && tlb_w_req_i.valid;
  assign inv_fire = idle && tlb_inv_req_i.valid && (tlb_inv_req_i.op <= INV_LAST_OP);

  // Entry as seen by lookups: stored payload with the live E bit spliced in.
  always_comb begin
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      ent_view[i]       = ent_q[i];
      ent_view[i].key.e = e_q[i];
    end
  end

  // Search comparators, one per entry. The op input is irrelevant here.
  logic [TLB_ENTRY_NUM-1:0] srch_vec;
  logic [TLB_ENTRY_NUM-1:0] srch_inv_unused;

  for (genvar gi = 0; gi < TLB_ENTRY_NUM; gi++) begin : g_srch
    tlb_entry_match u_match (
      .key_i      (ent_view[gi].key),
      .asid_i     (srch_asid_i),
      .vppn_i     (srch_vppn_i),
      .op_i       (INV_ALL0),
      .srch_hit_o (srch_vec[gi]),
      .inv_hit_o  (srch_inv_unused[gi])
    );
  end

  // Sweep window: SWEEP_WIDTH consecutive entries starting at ptr_q.
  logic [INDEX_LEN-1:0]   win_idx [SWEEP_WIDTH];
  logic [SWEEP_WIDTH-1:0] win_hit;
  logic [SWEEP_WIDTH-1:0] win_srch_unused;

  for (genvar gk = 0; gk < SWEEP_WIDTH; gk++) begin : g_win
    assign win_idx[gk] = ptr_q + INDEX_LEN'(gk);
    tlb_entry_match u_match (
      .key_i      (ent_view[win_idx[gk]].key),
      .asid_i     (asid_q),
      .vppn_i     (vppn_q),
      .op_i       (op_q),
      .srch_hit_o (win_srch_unused[gk]),
      .inv_hit_o  (win_hit[gk])
    );
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_d         = op_q;
    asid_d       = asid_q;
    vppn_d       = vppn_q;
    e_d          = e_q;
    ent_d        = ent_q;
    rd_entry_d   = ent_view[rd_index_i];
    srch_hit_d   = srch_hit_q;
    srch_index_d = srch_index_q;

    // A write accepted together with an INVTLB lands first, so the sweep sees it.
    if (wr_fire) begin
      ent_d[tlb_w_req_i.index] = tlb_w_req_i.entry;
      e_d[tlb_w_req_i.index]   = tlb_w_req_i.entry.key.e;
    end

    case (state_q)
      ST_IDLE: begin
        if (inv_fire) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
          op_d    = tlb_inv_req_i.op;
          asid_d  = tlb_inv_req_i.asid;
          vppn_d  = tlb_inv_req_i.vppn;
        end
      end
      ST_SWEEP: begin
        for (int k = 0; k < SWEEP_WIDTH; k++) begin
          if (win_hit[k]) e_d[win_idx[k]] = 1'b0;
        end
        ptr_d = ptr_q + PTR_STEP;  // wraps to 0 after the last group
        if (ptr_q == PTR_LAST) state_d = ST_IDLE;
      end
    endcase

    // Lowest hitting index wins: scan downwards so the last assignment is the lowest.
    if (srch_valid_i) begin
      srch_hit_d   = |srch_vec;
      srch_index_d = '0;
      for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
        if (srch_vec[i]) srch_index_d = INDEX_LEN'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      op_q         <= '0;
      asid_q       <= '0;
      vppn_q       <= '0;
      e_q          <= '0;
      rd_entry_q   <= '0;
      srch_hit_q   <= 1'b0;
      srch_index_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_q         <= op_d;
      asid_q       <= asid_d;
      vppn_q       <= vppn_d;
      e_q          <= e_d;
      rd_entry_q   <= rd_entry_d;
      srch_hit_q   <= srch_hit_d;
      srch_index_q <= srch_index_d;
    end
  end

  // Payload only; validity is carried by e_q.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign busy_o       = (state_q == ST_SWEEP);
  assign rd_entry_o   = rd_entry_q;
  assign srch_hit_o   = srch_hit_q;
  assign srch_index_o = srch_index_q;

  // Upstream must hold off write/inv requests while a sweep runs.
  busy_no_req_a: assert property (@(posedge clk) disable iff (rst)
    busy_o |-> !(tlb_w_req_i.valid || tlb_inv_req_i.valid));

endmodule

// File: tb/tb_tlb_array.sv
module tb_tlb_array;
  import tlb_array_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  tlb_w_req_t           w_req;
  tlb_inv_req_t         inv_req;
  logic                 busy;
  logic [INDEX_LEN-1:0] rd_index;
  tlb_entry_t           rd_entry;
  logic                 srch_valid;
  logic [9:0]           srch_asid;
  logic [18:0]          srch_vppn;
  logic                 srch_hit;
  logic [INDEX_LEN-1:0] srch_index;

  always #5 clk = ~clk;

  tlb_array dut (
    .clk          (clk),
    .rst          (rst),
    .tlb_w_req_i  (w_req),
    .tlb_inv_req_i(inv_req),
    .busy_o       (busy),
    .rd_index_i   (rd_index),
    .rd_entry_o   (rd_entry),
    .srch_valid_i (srch_valid),
    .srch_asid_i  (srch_asid),
    .srch_vppn_i  (srch_vppn),
    .srch_hit_o   (srch_hit),
    .srch_index_o (srch_index)
  );

  int checks = 0;
  int errors = 0;

  tlb_entry_t mdl [TLB_ENTRY_NUM];

  typedef struct {
    logic                 hit;
    logic [INDEX_LEN-1:0] idx;
    string                name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic                 wr;
    logic                 same;
    logic [INDEX_LEN-1:0] wr_idx;
    tlb_entry_t           wr_ent;
    logic [9:0]           s_asid;
    logic [18:0]          s_vppn;
    logic                 exp_hit;
    logic [INDEX_LEN-1:0] exp_idx;
    string                name;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tlb_entry_t mk(input logic [18:0] vppn, input logic [5:0] ps, input logic g,
                                    input logic [9:0] asid, input logic e, input int seed);
    tlb_entry_t t;
    t.key.vppn   = vppn;
    t.key.ps     = ps;
    t.key.g      = g;
    t.key.asid   = asid;
    t.key.e      = e;
    t.value.ppn0 = 20'(seed * 7 + 1);
    t.value.plv0 = 2'(seed);
    t.value.mat0 = 2'(seed + 1);
    t.value.d0   = seed[0];
    t.value.v0   = 1'b1;
    t.value.ppn1 = 20'(seed * 13 + 5);
    t.value.plv1 = 2'(seed + 2);
    t.value.mat1 = 2'(seed + 3);
    t.value.d1   = seed[1];
    t.value.v1   = seed[2];
    return t;
  endfunction

  // Search scoreboard: each search issued pushes its expectation; this pops it
  // when the registered result appears one cycle later.
  always @(posedge clk) begin : mon
    exp_t e;
    if (!rst && srch_valid) begin
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL srch_unexpected: got result with no pending expectation");
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_hit"}, 128'(srch_hit), 128'(e.hit));
        chk({e.name, "_idx"}, 128'(srch_index), 128'(e.idx));
      end
    end
  end

  task automatic srch(input logic [9:0] a, input logic [18:0] v, input logic h,
                      input logic [INDEX_LEN-1:0] i, input string n);
    srch_valid = 1'b1;
    srch_asid  = a;
    srch_vppn  = v;
    sb_q.push_back('{hit: h, idx: i, name: n});
    tick();
    srch_valid = 1'b0;
  endtask

  task automatic wr(input logic [INDEX_LEN-1:0] idx, input tlb_entry_t ent);
    w_req.valid = 1'b1;
    w_req.index = idx;
    w_req.entry = ent;
    mdl[idx]    = ent;
    tick();
    w_req.valid = 1'b0;
  endtask

  task automatic check_all_e(input string n);
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      rd_index = INDEX_LEN'(i);
      tick();
      chk($sformatf("%s_e%0d", n, i), 128'(rd_entry.key.e), 128'(mdl[i].key.e));
    end
  endtask

  task automatic issue_inv(input logic [4:0] op, input logic [9:0] a, input logic [18:0] v);
    inv_req.valid = 1'b1;
    inv_req.op    = op;
    inv_req.asid  = a;
    inv_req.vppn  = v;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tlb_entry_t ea, eb, tmp;
    int         cnt;
    logic       seen;

    rst        = 1'b1;
    w_req      = '0;
    inv_req    = '0;
    srch_valid = 1'b0;
    srch_asid  = '0;
    srch_vppn  = '0;
    rd_index   = '0;
    for (int i = 0; i < TLB_ENTRY_NUM; i++) mdl[i] = '0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_rd_entry", 128'(rd_entry), 128'(0));
    chk("rst_srch_hit", 128'(srch_hit), 128'(1'b0));
    chk("rst_srch_idx", 128'(srch_index), 128'(0));
    rst      = 1'b0;
    rd_index = 5'd5;
    tick();
    chk("rst_e5", 128'(rd_entry.key.e), 128'(1'b0));
    srch(10'd7, 19'h12345, 1'b0, 5'd0, "rst_srch");

    // Table-driven write/search vectors
    ea = mk(19'h12345, PS_4K, 1'b0, 10'd7, 1'b1, 1);
    eb = mk(19'h12200, PS_2M, 1'b0, 10'd7, 1'b1, 4);
    vecs.push_back('{1, 0, 5'd3,  ea, 10'd7, 19'h12345, 1, 5'd3, "wr3"});
    vecs.push_back('{0, 0, 5'd0,  ea, 10'd8, 19'h12345, 0, 5'd0, "asid_miss"});
    vecs.push_back('{1, 0, 5'd9,  ea, 10'd7, 19'h12345, 1, 5'd3, "dup9_low3"});
    vecs.push_back('{1, 0, 5'd2,  ea, 10'd7, 19'h12345, 1, 5'd2, "dup2_low"});
    tmp = ea; tmp.key.e = 1'b0;
    vecs.push_back('{1, 0, 5'd2,  tmp, 10'd7, 19'h12345, 1, 5'd3, "e0_idx2"});
    vecs.push_back('{1, 0, 5'd9,  tmp, 10'd7, 19'h12345, 1, 5'd3, "e0_idx9"});
    vecs.push_back('{1, 0, 5'd4,  eb, 10'd7, 19'h123FF, 1, 5'd4, "ps21_hit"});
    vecs.push_back('{0, 0, 5'd0,  eb, 10'd7, 19'h12345, 1, 5'd3, "ps21_vs_4k"});
    vecs.push_back('{0, 0, 5'd0,  eb, 10'd7, 19'h12400, 0, 5'd0, "ps21_range"});
    vecs.push_back('{1, 0, 5'd3,  tmp, 10'd7, 19'h12345, 1, 5'd4, "fall_to_4"});
    vecs.push_back('{1, 0, 5'd10, mk(19'h00ABC, PS_4K, 1'b1, 10'd5, 1'b1, 10),
                     10'd99, 19'h00ABC, 1, 5'd10, "global"});
    vecs.push_back('{1, 1, 5'd1,  mk(19'h55555, PS_4K, 1'b0, 10'd3, 1'b1, 11),
                     10'd3, 19'h55555, 0, 5'd0, "rbw_srch"});
    vecs.push_back('{0, 0, 5'd0,  ea, 10'd3, 19'h55555, 1, 5'd1, "after_rbw"});

    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].wr) begin
        w_req.valid = 1'b1;
        w_req.index = vecs[r].wr_idx;
        w_req.entry = vecs[r].wr_ent;
        mdl[vecs[r].wr_idx] = vecs[r].wr_ent;
        if (!vecs[r].same) begin
          tick();
          w_req.valid = 1'b0;
        end
      end
      srch(vecs[r].s_asid, vecs[r].s_vppn, vecs[r].exp_hit, vecs[r].exp_idx, vecs[r].name);
      w_req.valid = 1'b0;
    end

    // Search result holds while no new search is issued
    tick(); tick();
    chk("srch_hold_hit", 128'(srch_hit), 128'(1'b1));
    chk("srch_hold_idx", 128'(srch_index), 128'(1));

    // Read is read-before-write, then sees the new entry
    rd_index = 5'd6;
    wr(5'd6, mk(19'h0ABCD, PS_4K, 1'b0, 10'd2, 1'b1, 6));
    chk("rbw_rd_e", 128'(rd_entry.key.e), 128'(1'b0));
    tick();
    chk("rd_after_wr", 128'(rd_entry), 128'(mdl[6]));

    // Fill all entries, odd ones global, then INVTLB op 3
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      wr(INDEX_LEN'(i), mk(19'(i * 256 + 1), PS_4K, i[0], 10'(i), 1'b1, i + 20));
    end
    rd_index = 5'd7;
    tick();
    chk("rd_full7", 128'(rd_entry), 128'(mdl[7]));
    issue_inv(5'd3, 10'd0, 19'd0);
    tick();
    inv_req.valid = 1'b0;
    chk("busy_start", 128'(busy), 128'(1'b1));
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy) cnt++;
      else if (cnt > 0) break;
      tick();
    end
    chk("busy_len", 128'(cnt), 128'(TLB_ENTRY_NUM / SWEEP_WIDTH));
    for (int i = 0; i < TLB_ENTRY_NUM; i++) if (!i[0]) mdl[i].key.e = 1'b0;
    check_all_e("op3");

    // INVTLB op 6 issued alongside a write of a matching entry at idx0
    w_req.valid = 1'b1;
    w_req.index = 5'd0;
    w_req.entry = mk(19'h0F0F0, PS_4K, 1'b0, 10'd7, 1'b1, 40);
    mdl[0]      = w_req.entry;
    issue_inv(5'd6, 10'd7, 19'h0F0F0);
    tick();
    w_req.valid   = 1'b0;
    inv_req.valid = 1'b0;
    for (int c = 0; c < 20 && busy; c++) tick();
    chk("op6_done", 128'(busy), 128'(1'b0));
    mdl[0].key.e = 1'b0;
    check_all_e("op6");

    // op 7 is a no-op
    issue_inv(5'd7, 10'd0, 19'd0);
    tick();
    inv_req.valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy) seen = 1'b1;
      tick();
    end
    chk("op7_no_busy", 128'(seen), 128'(1'b0));
    check_all_e("op7");

    // Reset in the 3rd sweep cycle
    issue_inv(5'd0, 10'd0, 19'd0);
    tick();
    inv_req.valid = 1'b0;
    tick();
    tick();
    chk("sweep3_busy", 128'(busy), 128'(1'b1));
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", 128'(busy), 128'(1'b0));
    chk("rst_mid_rd", 128'(rd_entry), 128'(0));
    chk("rst_mid_hit", 128'(srch_hit), 128'(1'b0));
    rst = 1'b0;
    for (int i = 0; i < TLB_ENTRY_NUM; i++) mdl[i].key.e = 1'b0;
    wr(5'd5, mk(19'h7E7E7, PS_4K, 1'b0, 10'd9, 1'b1, 55));
    srch(10'd9, 19'h7E7E7, 1'b1, 5'd5, "post_rst_wr");
    rd_index = 5'd5;
    tick();
    chk("post_rst_rd", 128'(rd_entry), 128'(mdl[5]));
    check_all_e("post_rst");

    tick();
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
